// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V subset core: opcodes, NOP encoding, fetch FSM states, error causes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // Major opcodes decoded by the control unit
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_MISALIGN = 2'b10
    } err_cause_t;

    // Instruction addresses must be word aligned
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory handshake, decode-facing instruction, retire/branch inputs, error status.
// Latency: n/a (wiring only).
// Backpressure: memory stalls fetch via imem_ready; execute holds an instruction by withholding instr_ack.
interface instruction_fetch_if;
    // instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    // decode / execute side
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        funct7_5;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ack;
    logic        S_Mux_A;
    logic [31:0] branch_target;
    // status
    logic        fetch_err;
    logic [1:0]  err_cause;

    // master: the fetch unit
    modport master (
        output imem_req, imem_addr, instr, opcode, funct7_5, pc_out,
               instr_valid, fetch_err, err_cause,
        input  imem_rdata, imem_ready, instr_ack, S_Mux_A, branch_target
    );

    // slave: memory plus execute/control environment
    modport slave (
        input  imem_req, imem_addr, instr, opcode, funct7_5, pc_out,
               instr_valid, fetch_err, err_cause,
        output imem_rdata, imem_ready, instr_ack, S_Mux_A, branch_target
    );
endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with next-PC select between pc+4 and a branch target.
// Latency: new PC visible one cycle after load.
// Backpressure: none; holds value whenever load is low.
// Ports: clk, rst (async high), load, sel_target, target[31:0] in; pc[31:0] out.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sel_target,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    // pc + 4 wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= sel_target ? target : pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds PC, fetches from instruction memory, presents instruction to decode.
// Latency: VALID k+1 cycles after FETCH entry for k memory wait states; 2 cycles/instr minimum.
// Backpressure: waits up to MAX_WAIT cycles for imem_ready (then sticky error); holds instr until instr_ack.
// Ports: clk, rst (async high); bus (instruction_fetch_if.master) carries memory, decode and status signals.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_if.master        bus
);

    // Last FETCH cycle on which a ready is still accepted has wait_cnt == MAX_WAIT-1
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t state, state_nxt;
    err_cause_t   err_q, err_nxt;
    logic [7:0]   wait_cnt;
    logic [31:0]  instr_q;
    logic [31:0]  pc;
    logic         pc_load;
    logic         instr_load;
    logic         err_set;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (pc_load),
        .sel_target (bus.S_Mux_A),
        .target     (bus.branch_target),
        .pc         (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        err_set    = 1'b0;
        err_nxt    = ERR_NONE;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    instr_load = 1'b1;
                    state_nxt  = ST_VALID;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_set   = 1'b1;
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = ST_ERROR;
                end
            end
            ST_VALID: begin
                if (bus.instr_ack) begin
                    // A taken branch to a non-word address is fatal; PC keeps the faulting instruction's address
                    if (bus.S_Mux_A && !is_word_aligned(bus.branch_target)) begin
                        err_set   = 1'b1;
                        err_nxt   = ERR_MISALIGN;
                        state_nxt = ST_ERROR;
                    end else begin
                        pc_load   = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counts FETCH cycles; outside FETCH it sits at zero so every FETCH entry starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_FETCH) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
        end else if (instr_load) begin
            instr_q <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= ERR_NONE;
        end else if (err_set) begin
            err_q <= err_nxt;
        end
    end

    // All outputs come from registers or state decode
    assign bus.imem_req    = (state == ST_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.pc_out      = pc;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[6:0];
    assign bus.funct7_5    = instr_q[30];
    assign bus.instr_valid = (state == ST_VALID);
    assign bus.fetch_err   = (state == ST_ERROR);
    assign bus.err_cause   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, corner sequences, randomized run vs model.
// Latency: n/a.
// Backpressure: bench plays memory (random wait states) and execute (random ack delay).
module tb_instruction_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MAXW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch #(
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        logic        taken;
        logic [31:0] target;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, check reset values, release; returns one cycle after release with DUT in FETCH
    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.instr_ack  = 1'b0;
        #1;
        chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr,                NOP_INSTR);
        chk("rst_pc",    bus.pc_out,               RST_PC);
        chk("rst_err",   {31'd0, bus.fetch_err},   32'd0);
        chk("rst_cause", {30'd0, bus.err_cause},   32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
        step();
    endtask

    // Entered on the first FETCH cycle: memory answers after `waits` idle cycles, then VALID is checked
    task automatic run_fetch(input int waits, input logic [31:0] data, input logic [31:0] exp_addr);
        int   cyc;
        logic seen;
        logic [31:0] junk;
        cyc  = 0;
        seen = 1'b0;
        chk("fetch_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("fetch_addr", bus.imem_addr, exp_addr);
        for (int c = 0; c < 20 && !seen; c++) begin
            junk = $urandom;
            bus.imem_ready = (c == waits);
            bus.imem_rdata = (c == waits) ? data : junk;
            step();
            cyc++;
            bus.imem_ready = 1'b0;
            if (bus.instr_valid) seen = 1'b1;
        end
        chk("valid_latency", cyc, waits + 1);
        chk("valid_instr",   bus.instr, data);
        chk("valid_opcode",  {25'd0, bus.opcode}, {25'd0, data[6:0]});
        chk("valid_f7_5",    {31'd0, bus.funct7_5}, {31'd0, data[30]});
        chk("valid_pc",      bus.pc_out, exp_addr);
        chk("valid_noreq",   {31'd0, bus.imem_req}, 32'd0);
    endtask

    // Ack in the current VALID cycle
    task automatic do_ack(input logic taken, input logic [31:0] target);
        bus.instr_ack     = 1'b1;
        bus.S_Mux_A       = taken;
        bus.branch_target = target;
        step();
        bus.instr_ack     = 1'b0;
        bus.S_Mux_A       = 1'b0;
    endtask

    logic [31:0] model_pc;
    logic [31:0] rdat;
    logic [31:0] tgt;
    logic        tk;
    int          hold;

    initial begin
        bus.imem_rdata    = 32'd0;
        bus.imem_ready    = 1'b0;
        bus.instr_ack     = 1'b0;
        bus.S_Mux_A       = 1'b0;
        bus.branch_target = 32'd0;

        tbl[0] = '{0, 32'h0000_0013, 1'b0, 32'h0,  32'h00};
        tbl[1] = '{2, 32'h00a0_0093, 1'b0, 32'h0,  32'h04};
        tbl[2] = '{2, 32'h4020_8133, 1'b0, 32'h0,  32'h08};
        tbl[3] = '{2, 32'h0001_21b7, 1'b0, 32'h0,  32'h0C};
        tbl[4] = '{2, 32'h0020_a023, 1'b1, 32'h40, 32'h10};
        tbl[5] = '{3, 32'h0000_2203, 1'b0, 32'h0,  32'h40};
        tbl[6] = '{1, 32'hfe00_0ee3, 1'b0, 32'h0,  32'h44};

        step();
        do_reset();

        // Directed vector table: sequential fetches, wait states up to the accepted limit, one branch
        for (int i = 0; i < 7; i++) begin
            run_fetch(tbl[i].waits, tbl[i].rdata, tbl[i].exp_addr);
            do_ack(tbl[i].taken, tbl[i].target);
        end

        // VALID holds without ack; stray imem_ready ignored
        run_fetch(0, 32'h0000_0033, 32'h48);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ready = 1'b1;
            bus.imem_rdata = 32'hdead_beef;
            step();
        end
        bus.imem_ready = 1'b0;
        chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("hold_instr", bus.instr, 32'h0000_0033);

        // PC wrap from the top of the address space
        do_ack(1'b1, 32'hFFFF_FFFC);
        run_fetch(0, 32'h0000_0013, 32'hFFFF_FFFC);
        do_ack(1'b0, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Reset during FETCH with a response pending: immediate return to reset values
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("midrst_instr", bus.instr, NOP_INSTR);
        chk("midrst_req",   {31'd0, bus.imem_req}, 32'd0);
        step();
        rst = 1'b0;
        step();
        bus.imem_ready = 1'b0;
        chk("postrst_instr", bus.instr, NOP_INSTR);
        chk("postrst_req",   {31'd0, bus.imem_req}, 32'd1);

        // Misaligned branch target
        run_fetch(0, 32'h0000_0063, RST_PC);
        do_ack(1'b1, 32'h42);
        chk("mis_err",   {31'd0, bus.fetch_err}, 32'd1);
        chk("mis_cause", {30'd0, bus.err_cause}, 32'd2);
        chk("mis_pc",    bus.pc_out, RST_PC);
        chk("mis_valid", {31'd0, bus.instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ready = 1'b1;
            bus.instr_ack  = 1'b1;
            step();
        end
        bus.imem_ready = 1'b0;
        bus.instr_ack  = 1'b0;
        chk("mis_sticky", {31'd0, bus.fetch_err}, 32'd1);
        chk("mis_noreq",  {31'd0, bus.imem_req}, 32'd0);
        do_reset();

        // Timeout: no ready for MAXW FETCH cycles
        for (int i = 0; i < MAXW - 1; i++) step();
        chk("to_still_fetch", {31'd0, bus.imem_req}, 32'd1);
        step();
        chk("to_err",   {31'd0, bus.fetch_err}, 32'd1);
        chk("to_cause", {30'd0, bus.err_cause}, 32'd1);
        chk("to_noreq", {31'd0, bus.imem_req}, 32'd0);
        step();
        chk("to_sticky", {31'd0, bus.fetch_err}, 32'd1);
        do_reset();

        // Randomized run against a transaction-level PC model
        model_pc = RST_PC;
        for (int n = 0; n < 150; n++) begin
            rdat = $urandom;
            run_fetch($urandom_range(0, MAXW - 1), rdat, model_pc);
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                bus.imem_ready = $urandom_range(0, 1);
                step();
            end
            bus.imem_ready = 1'b0;
            chk("rnd_held", bus.instr, rdat);
            tk  = $urandom_range(0, 1);
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            do_ack(tk, tgt);
            model_pc = tk ? tgt : model_pc + 32'd4;
        end
        chk("rnd_last_addr", bus.imem_addr, model_pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
